// File: rtl/updown_counter_ps.sv
// updown_counter_ps: up/down counter with a two-rate prescaler, programmable
// modulo limit, synchronous load and wrap/saturate selection.
// All outputs come straight from flops; tick and tc are single-cycle strobes.
`timescale 1ns/1ps
module updown_counter_ps #(
    parameter int WIDTH    = 8,
    parameter int DIV_SLOW = 50_000_000,
    parameter int DIV_FAST = 5_000_000
) (
    input  logic             clk50m,
    input  logic             reset,
    input  logic             speed,
    input  logic             UD,
    input  logic             SS,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             wrap_mode,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc
);

    // Prescaler is sized for the slow period; the fast period always fits.
    localparam int PW = (DIV_SLOW > 2) ? $clog2(DIV_SLOW) : 1;

    localparam logic [PW-1:0]    SLOW_LAST  = PW'(DIV_SLOW - 1);
    localparam logic [PW-1:0]    FAST_LAST  = PW'(DIV_FAST - 1);
    localparam logic [PW-1:0]    PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO   = WIDTH'(0);
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    // Loaded values never start above the current modulo maximum.
    function automatic logic [WIDTH-1:0] clamp_to_limit(
        input logic [WIDTH-1:0] value,
        input logic [WIDTH-1:0] lim
    );
        logic [WIDTH-1:0] result;
        if (value > lim) begin
            result = lim;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_out;
    logic             r_tick;
    logic             r_tc;

    logic [PW-1:0]    w_presc_last;
    logic             w_expire;
    logic [WIDTH-1:0] w_step_out;
    logic             w_step_tc;
    logic [PW-1:0]    w_presc_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_tick_nxt;
    logic             w_tc_nxt;

    // Expiry detect: >= (not ==) so a slow-to-fast switch with a large
    // prescaler value expires on the very next running edge.
    always_comb begin
        w_presc_last = SLOW_LAST;
        w_expire     = 1'b0;
        if (speed) begin
            w_presc_last = FAST_LAST;
        end else begin
            w_presc_last = SLOW_LAST;
        end
        if (SS && (r_presc >= w_presc_last)) begin
            w_expire = 1'b1;
        end else begin
            w_expire = 1'b0;
        end
    end

    // Count step taken on an expiry: clamp after a lowered limit, otherwise
    // move one step or handle the boundary (wrap or pin, flag tc).
    always_comb begin
        w_step_out = r_out;
        w_step_tc  = 1'b0;
        if (r_out > limit) begin
            w_step_out = limit;
            w_step_tc  = 1'b0;
        end else if (UD) begin
            if (r_out < limit) begin
                w_step_out = r_out + CNT_ONE;
            end else begin
                w_step_tc = 1'b1;
                if (wrap_mode) begin
                    w_step_out = CNT_ZERO;
                end else begin
                    w_step_out = limit;
                end
            end
        end else begin
            if (r_out > CNT_ZERO) begin
                w_step_out = r_out - CNT_ONE;
            end else begin
                w_step_tc = 1'b1;
                if (wrap_mode) begin
                    w_step_out = limit;
                end else begin
                    w_step_out = CNT_ZERO;
                end
            end
        end
    end

    // Next-state selection: load beats expiry; a stopped counter holds.
    always_comb begin
        w_presc_nxt = r_presc;
        w_out_nxt   = r_out;
        w_tick_nxt  = 1'b0;
        w_tc_nxt    = 1'b0;
        if (load) begin
            w_presc_nxt = PRESC_ZERO;
            w_out_nxt   = clamp_to_limit(load_val, limit);
        end else if (w_expire) begin
            w_presc_nxt = PRESC_ZERO;
            w_out_nxt   = w_step_out;
            w_tick_nxt  = 1'b1;
            w_tc_nxt    = w_step_tc;
        end else if (SS) begin
            w_presc_nxt = r_presc + PRESC_ONE;
        end else begin
            w_presc_nxt = r_presc;
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk50m or negedge reset) begin
        if (!reset) begin
            r_presc <= PRESC_ZERO;
            r_out   <= CNT_ZERO;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_presc <= w_presc_nxt;
            r_out   <= w_out_nxt;
            r_tick  <= w_tick_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign out  = r_out;
    assign tick = r_tick;
    assign tc   = r_tc;

endmodule
